// File: rtl/bp_mem_cmd_arb.sv
// bp_mem_cmd_arb
//   Two-requester round-robin arbiter in front of a single memory command
//   port. The ID of each accepted command goes into an in-order ID FIFO. When
//   memory responses come back, they are routed to the requester at the head
//   of that FIFO.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   reqN_cmd_i/_v_i/_ready_o    requester N command channel (valid-then-ready)
//   reqN_resp_o/_v_o/_yumi_i    requester N response channel
//   mem_cmd_o/_v_o/_ready_i     granted command towards memory
//   mem_resp_i/_v_i/_yumi_o     response from memory
//   outstanding_o               number of commands currently in flight
//   error_o                     sticky: a response arrived with nothing in flight
module bp_mem_cmd_arb #(
  parameter int cmd_width_p   = 128,
  parameter int resp_width_p  = 128,
  parameter int outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,

  input  logic [cmd_width_p-1:0]               req0_cmd_i,
  input  logic                                 req0_cmd_v_i,
  output logic                                 req0_cmd_ready_o,
  input  logic [cmd_width_p-1:0]               req1_cmd_i,
  input  logic                                 req1_cmd_v_i,
  output logic                                 req1_cmd_ready_o,

  output logic [resp_width_p-1:0]              req0_resp_o,
  output logic                                 req0_resp_v_o,
  input  logic                                 req0_resp_yumi_i,
  output logic [resp_width_p-1:0]              req1_resp_o,
  output logic                                 req1_resp_v_o,
  input  logic                                 req1_resp_yumi_i,

  output logic [cmd_width_p-1:0]               mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,

  input  logic [resp_width_p-1:0]              mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o,

  output logic [$clog2(outstanding_p+1)-1:0]   outstanding_o,
  output logic                                 error_o
);

  localparam int cnt_w_lp = $clog2(outstanding_p + 1);
  localparam int ptr_w_lp = $clog2(outstanding_p);
  localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(outstanding_p);

  // State
  logic                 lg_r;
  logic [ptr_w_lp-1:0]  wr_ptr_r;
  logic [ptr_w_lp-1:0]  rd_ptr_r;
  logic [cnt_w_lp-1:0]  outstanding_r;
  logic                 error_r;
  logic                 id_fifo_r [outstanding_p];

  // Combinational
  logic grant_id_s;
  logic full_s;
  logic empty_s;
  logic cmd_v_s;
  logic accept_s;
  logic head_id_s;
  logic head_yumi_s;
  logic pop_s;
  logic spurious_s;

  // Full and empty come from the in-flight count, because the two pointers
  // are equal in both cases.
  assign full_s  = (outstanding_r == max_cnt_lp);
  assign empty_s = (outstanding_r == {cnt_w_lp{1'b0}});

  // Round-robin pick. On a tie the requester that did not win last time is
  // chosen. A lone valid requester always wins.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_cmd_v_i && req1_cmd_v_i) begin
      grant_id_s = ~lg_r;
    end else if (req1_cmd_v_i) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Readiness depends only on registered state and mem_cmd_ready_i. There is
  // no full bypass, so no response yumi can reach the cmd_ready outputs.
  assign cmd_v_s          = reset_n_i & (req0_cmd_v_i | req1_cmd_v_i) & ~full_s;
  assign accept_s         = cmd_v_s & mem_cmd_ready_i;
  assign mem_cmd_v_o      = cmd_v_s;
  assign mem_cmd_o        = grant_id_s ? req1_cmd_i : req0_cmd_i;
  assign req0_cmd_ready_o = accept_s & ~grant_id_s;
  assign req1_cmd_ready_o = accept_s &  grant_id_s;

  // Response routing uses the registered FIFO head. A command pushed this
  // cycle therefore cannot be answered until the next cycle.
  assign head_id_s       = id_fifo_r[rd_ptr_r];
  assign head_yumi_s     = head_id_s ? req1_resp_yumi_i : req0_resp_yumi_i;
  assign pop_s           = reset_n_i & mem_resp_v_i & ~empty_s & head_yumi_s;
  assign spurious_s      = reset_n_i & mem_resp_v_i & empty_s;
  assign req0_resp_v_o   = reset_n_i & mem_resp_v_i & ~empty_s & ~head_id_s;
  assign req1_resp_v_o   = reset_n_i & mem_resp_v_i & ~empty_s &  head_id_s;
  assign req0_resp_o     = mem_resp_i;
  assign req1_resp_o     = mem_resp_i;
  // A response with nothing in flight is consumed and dropped.
  assign mem_resp_yumi_o = pop_s | spurious_s;

  assign outstanding_o = outstanding_r;
  assign error_o       = error_r;

  // Last-grant bit, ID FIFO, in-flight counter and sticky error flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lg_r          <= 1'b1;
      wr_ptr_r      <= {ptr_w_lp{1'b0}};
      rd_ptr_r      <= {ptr_w_lp{1'b0}};
      outstanding_r <= {cnt_w_lp{1'b0}};
      error_r       <= 1'b0;
      for (int i = 0; i < outstanding_p; i++) begin
        id_fifo_r[i] <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        lg_r                <= grant_id_s;
        id_fifo_r[wr_ptr_r] <= grant_id_s;
        wr_ptr_r            <= wr_ptr_r + ptr_w_lp'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + cnt_w_lp'(1);
        2'b01:   outstanding_r <= outstanding_r - cnt_w_lp'(1);
        default: outstanding_r <= outstanding_r;
      endcase
      if (spurious_s) begin
        error_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_mem_cmd_arb.sv
module tb_bp_mem_cmd_arb;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [127:0] req0_cmd_i, req1_cmd_i;
  logic         req0_cmd_v_i, req1_cmd_v_i;
  logic         req0_cmd_ready_o, req1_cmd_ready_o;
  logic [127:0] req0_resp_o, req1_resp_o;
  logic         req0_resp_v_o, req1_resp_v_o;
  logic         req0_resp_yumi_i, req1_resp_yumi_i;
  logic [127:0] mem_cmd_o;
  logic         mem_cmd_v_o, mem_cmd_ready_i;
  logic [127:0] mem_resp_i;
  logic         mem_resp_v_i, mem_resp_yumi_o;
  logic [2:0]   outstanding_o;
  logic         error_o;

  int n_vec     = 0;
  int n_miscmp  = 0;

  localparam logic [127:0] cmd0_c = 128'h0000_00A0;
  localparam logic [127:0] cmd1_c = 128'h0000_00B1;
  localparam logic [127:0] resp_c = 128'hDEAD_BEEF_0000_5A5A;

  bp_mem_cmd_arb dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req0_cmd_i(req0_cmd_i), .req0_cmd_v_i(req0_cmd_v_i), .req0_cmd_ready_o(req0_cmd_ready_o),
    .req1_cmd_i(req1_cmd_i), .req1_cmd_v_i(req1_cmd_v_i), .req1_cmd_ready_o(req1_cmd_ready_o),
    .req0_resp_o(req0_resp_o), .req0_resp_v_o(req0_resp_v_o), .req0_resp_yumi_i(req0_resp_yumi_i),
    .req1_resp_o(req1_resp_o), .req1_resp_v_o(req1_resp_v_o), .req1_resp_yumi_i(req1_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, landing 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic g0, input logic g1);
    chk({tag, ".rdy0"}, {127'b0, req0_cmd_ready_o}, {127'b0, g0});
    chk({tag, ".rdy1"}, {127'b0, req1_cmd_ready_o}, {127'b0, g1});
  endtask

  task automatic chk_resp(input string tag, input logic v0, input logic v1, input logic y);
    chk({tag, ".rv0"},  {127'b0, req0_resp_v_o},   {127'b0, v0});
    chk({tag, ".rv1"},  {127'b0, req1_resp_v_o},   {127'b0, v1});
    chk({tag, ".yumi"}, {127'b0, mem_resp_yumi_o}, {127'b0, y});
  endtask

  logic [3:0] drain_ids;
  logic [2:0] ord_ids;

  initial begin
    reset_n_i        = 1'b0;
    req0_cmd_i       = cmd0_c;
    req1_cmd_i       = cmd1_c;
    req0_cmd_v_i     = 1'b1;
    req1_cmd_v_i     = 1'b1;
    req0_resp_yumi_i = 1'b0;
    req1_resp_yumi_i = 1'b0;
    mem_cmd_ready_i  = 1'b1;
    mem_resp_i       = resp_c;
    mem_resp_v_i     = 1'b1;
    #2;
    // While reset is held, every handshake output is forced low even though
    // requests and a response are presented.
    chk("rst.outstanding", {125'b0, outstanding_o}, 128'd0);
    chk("rst.error", {127'b0, error_o}, 128'd0);
    chk("rst.cmd_v", {127'b0, mem_cmd_v_o}, 128'd0);
    chk_grant("rst", 1'b0, 1'b0);
    chk_resp("rst", 1'b0, 1'b0, 1'b0);
    mem_resp_v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;

    // Tie: grants alternate 0,1,0,1 and the count climbs to 4
    for (int i = 0; i < 4; i++) begin
      chk_grant($sformatf("tie%0d", i), (i % 2) == 0, (i % 2) == 1);
      chk($sformatf("tie%0d.cmd", i), mem_cmd_o, ((i % 2) == 0) ? cmd0_c : cmd1_c);
      tick();
      chk($sformatf("tie%0d.cnt", i), {125'b0, outstanding_o}, 128'(i + 1));
    end

    // Full: no valid, no ready, even while a pop happens
    chk("full.cmd_v", {127'b0, mem_cmd_v_o}, 128'd0);
    chk_grant("full", 1'b0, 1'b0);
    mem_resp_v_i = 1'b1;
    #1;
    // Head is requester 0. Hold its yumi low for five cycles.
    for (int i = 0; i < 5; i++) begin
      chk_resp($sformatf("bp%0d", i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("bp%0d.data", i), req0_resp_o, resp_c);
      tick();
      chk($sformatf("bp%0d.cnt", i), {125'b0, outstanding_o}, 128'd4);
    end
    req0_resp_yumi_i = 1'b1;
    #1;
    chk_resp("pop", 1'b1, 1'b0, 1'b1);
    chk_grant("pop.nobypass", 1'b0, 1'b0);
    tick();
    mem_resp_v_i     = 1'b0;
    req0_resp_yumi_i = 1'b0;
    #1;
    chk("pop.cnt", {125'b0, outstanding_o}, 128'd3);
    // The last grant was requester 1, so this tie goes to requester 0.
    chk_grant("regrant", 1'b1, 1'b0);
    tick();
    chk("regrant.cnt", {125'b0, outstanding_o}, 128'd4);

    // Drain: remaining IDs in order are 1,0,1,0
    req0_cmd_v_i     = 1'b0;
    req1_cmd_v_i     = 1'b0;
    mem_resp_v_i     = 1'b1;
    req0_resp_yumi_i = 1'b1;
    req1_resp_yumi_i = 1'b1;
    drain_ids        = 4'b0101;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_resp($sformatf("drain%0d", k), ~drain_ids[k], drain_ids[k], 1'b1);
      tick();
    end
    mem_resp_v_i = 1'b0;
    #1;
    chk("drain.cnt", {125'b0, outstanding_o}, 128'd0);

    // Ordering: issue req1, req0, then req1 together with the first response
    ord_ids      = 3'b101;
    req1_cmd_v_i = 1'b1;
    #1;
    chk("ord0.cmd", mem_cmd_o, cmd1_c);
    chk_grant("ord0", 1'b0, 1'b1);
    tick();
    req1_cmd_v_i = 1'b0;
    req0_cmd_v_i = 1'b1;
    #1;
    chk_grant("ord1", 1'b1, 1'b0);
    tick();
    req0_cmd_v_i = 1'b0;
    req1_cmd_v_i = 1'b1;
    mem_resp_v_i = 1'b1;
    #1;
    chk_grant("ord2", 1'b0, 1'b1);
    chk_resp("ord.r0", ~ord_ids[0], ord_ids[0], 1'b1);
    tick();
    req1_cmd_v_i = 1'b0;
    #1;
    chk("ord.pushpop.cnt", {125'b0, outstanding_o}, 128'd2);
    for (int k = 1; k < 3; k++) begin
      chk_resp($sformatf("ord.r%0d", k), ~ord_ids[k], ord_ids[k], 1'b1);
      tick();
    end
    chk("ord.cnt", {125'b0, outstanding_o}, 128'd0);

    // Spurious response with an empty FIFO while a push happens the same cycle
    req0_cmd_v_i = 1'b1;
    #1;
    chk_resp("spur", 1'b0, 1'b0, 1'b1);
    chk_grant("spur", 1'b1, 1'b0);
    tick();
    req0_cmd_v_i = 1'b0;
    #1;
    chk("spur.error", {127'b0, error_o}, 128'd1);
    chk("spur.cnt", {125'b0, outstanding_o}, 128'd1);
    chk_resp("spur.next", 1'b1, 1'b0, 1'b1);
    tick();
    mem_resp_v_i = 1'b0;
    tick();
    chk("spur.sticky", {127'b0, error_o}, 128'd1);
    chk("spur.cnt0", {125'b0, outstanding_o}, 128'd0);

    // Reset mid-flight: three requester-0 commands, so the last grant is 0
    req0_cmd_v_i = 1'b1;
    repeat (3) tick();
    req0_cmd_v_i = 1'b0;
    #1;
    chk("mid.cnt", {125'b0, outstanding_o}, 128'd3);
    req0_cmd_v_i = 1'b1;
    req1_cmd_v_i = 1'b1;
    reset_n_i    = 1'b0;
    #1;
    chk("mid.rst.cnt", {125'b0, outstanding_o}, 128'd0);
    chk("mid.rst.error", {127'b0, error_o}, 128'd0);
    chk_grant("mid.rst", 1'b0, 1'b0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    chk_grant("mid.tie", 1'b1, 1'b0);
    tick();
    chk("mid.first.cnt", {125'b0, outstanding_o}, 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
